// File: rtl/backend_id_allocator.sv
// -----------------------------------------------------------------------------
// backend_id_allocator
//
// Backend-side responder for the issue-stage protocol. Each accepted request
// is given a transaction ID from a pool of NUM_IDS. The ID goes back to the
// issue stage on the reply channel. In parallel, the request payload is
// forwarded to the memory side tagged with that ID. The memory side releases
// IDs on completion, which bounds the number of outstanding lookups.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_data_i/valid_i/ready_o request channel from the issue stage
//   rsp_data_o/valid_o/ready_i reply to the issue stage; low ID_WIDTH bits
//                              hold the ID, upper bits are zero
//   mem_data_o/id_o/valid_o/ready_i  request forwarded to the memory side
//   free_id_i, free_valid_i    ID release strobe (single cycle, no backpressure)
//   outstanding_o              number of IDs currently allocated
//   free_err_o                 sticky flag for a release of an unallocated or
//                              out-of-range ID
//
// Build option:
//   BACKEND_ID_ALLOC_ROUND_ROBIN_EN -- when defined, the search for a free ID
//   starts at a rotating pointer instead of at index 0.
// -----------------------------------------------------------------------------
module backend_id_allocator #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IDS    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_IDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [ID_WIDTH-1:0]   mem_id_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  input  logic [ID_WIDTH-1:0]   free_id_i,
  input  logic                  free_valid_i,
  output logic [ID_WIDTH:0]     outstanding_o,
  output logic                  free_err_o
);

  logic [NUM_IDS-1:0]    alloc_q, alloc_d;
  logic [ID_WIDTH:0]     outstanding_q, outstanding_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;
  logic                  free_err_q, free_err_d;

  logic                  any_free;
  logic [ID_WIDTH-1:0]   chosen_id;
  logic                  accept;
  logic                  free_ok;

  // Freeing and allocation both look at the bitmap as registered at the start
  // of the cycle, so a released ID cannot be handed out in its release cycle.
  assign any_free = ~(&alloc_q);

  // Gated with rst_ni so the issue stage never sees ready while in reset.
  assign req_ready_o = rst_ni & any_free
                     & (~rsp_valid_q | rsp_ready_i)
                     & (~mem_valid_q | mem_ready_i);
  assign accept = req_valid_i & req_ready_o;

`ifdef BACKEND_ID_ALLOC_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  // Walk the candidates from farthest to nearest (relative to ptr_q), so the
  // last match written is the first free index at or after the pointer.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch, otherwise an
    // unassigned path infers a latch.
    chosen_id = '0;
    idx       = 0;
    for (int k = NUM_IDS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_IDS) idx = idx - NUM_IDS;
      if (!alloc_q[idx]) chosen_id = ID_WIDTH'(idx);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (chosen_id == ID_WIDTH'(NUM_IDS - 1)) ? '0 : chosen_id + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  // Descending scan: the last match written is the lowest free index.
  always_comb begin
    chosen_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) chosen_id = ID_WIDTH'(i);
    end
  end
`endif

  // A release counts only if it names an allocated ID. The equality decode
  // also rejects out-of-range IDs when NUM_IDS is not a power of two.
  always_comb begin
    free_ok = 1'b0;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (free_valid_i && free_id_i == ID_WIDTH'(i) && alloc_q[i]) free_ok = 1'b1;
    end
  end

  always_comb begin
    alloc_d       = alloc_q;
    outstanding_d = outstanding_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    mem_valid_d   = mem_valid_q;
    mem_data_d    = mem_data_q;
    mem_id_d      = mem_id_q;
    free_err_d    = free_err_q | (free_valid_i & ~free_ok);

    // The accepted ID is free and the released ID is allocated, so the two
    // never touch the same bit.
    if (accept)  alloc_d[chosen_id] = 1'b1;
    if (free_ok) alloc_d[free_id_i] = 1'b0;
    outstanding_d = outstanding_q + (ID_WIDTH+1)'(accept) - (ID_WIDTH+1)'(free_ok);

    // Both output registers are loaded together on accept. When there is no
    // accept, each one drains on its own handshake.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = chosen_id;
      mem_valid_d = 1'b1;
      mem_data_d  = req_data_i;
      mem_id_d    = chosen_id;
    end else begin
      if (rsp_ready_i) rsp_valid_d = 1'b0;
      if (mem_ready_i) mem_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering. The ID bitmap is only
  // NUM_IDS flops, so it is reset like any other register. A reset mid-run
  // must drop every in-flight ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q       <= '0;
      outstanding_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      mem_valid_q   <= 1'b0;
      mem_data_q    <= '0;
      mem_id_q      <= '0;
      free_err_q    <= 1'b0;
    end else begin
      alloc_q       <= alloc_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      mem_valid_q   <= mem_valid_d;
      mem_data_q    <= mem_data_d;
      mem_id_q      <= mem_id_d;
      free_err_q    <= free_err_d;
    end
  end

  always_comb begin
    rsp_data_o                 = '0;
    rsp_data_o[ID_WIDTH-1:0]   = rsp_id_q;
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign mem_data_o    = mem_data_q;
  assign mem_id_o      = mem_id_q;
  assign mem_valid_o   = mem_valid_q;
  assign outstanding_o = outstanding_q;
  assign free_err_o    = free_err_q;

endmodule

// File: tb/tb_backend_id_allocator.sv
// -----------------------------------------------------------------------------
// tb_backend_id_allocator
//
// Self-checking bench for backend_id_allocator. It runs directed scenarios
// followed by randomized traffic. Every cycle is predicted by a pool model,
// which tracks which IDs are held, the two pending output slots and the
// sticky error flag.
// -----------------------------------------------------------------------------
module tb_backend_id_allocator;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_IDS    = 4;
  localparam int ID_WIDTH   = $clog2(NUM_IDS);

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [ID_WIDTH-1:0]   mem_id_o;
  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ID_WIDTH-1:0]   free_id_i;
  logic                  free_valid_i;
  logic [ID_WIDTH:0]     outstanding_o;
  logic                  free_err_o;

  backend_id_allocator #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_IDS   (NUM_IDS)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .mem_data_o   (mem_data_o),
    .mem_id_o     (mem_id_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .free_id_i    (free_id_i),
    .free_valid_i (free_valid_i),
    .outstanding_o(outstanding_o),
    .free_err_o   (free_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_held[NUM_IDS];
  int        m_ptr;
  bit        m_rsp_v;
  int        m_rsp_id;
  bit        m_mem_v;
  logic [31:0] m_mem_data;
  int        m_mem_id;
  bit        m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NUM_IDS; i++) c += int'(m_held[i]);
    return c;
  endfunction

  // ID that would be handed out now, or -1 if none is free.
  function automatic int m_pick();
    int start = 0;
`ifdef BACKEND_ID_ALLOC_ROUND_ROBIN_EN
    start = m_ptr;
`endif
    for (int k = 0; k < NUM_IDS; k++) begin
      if (!m_held[(start + k) % NUM_IDS]) return (start + k) % NUM_IDS;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NUM_IDS; i++) m_held[i] = 1'b0;
    m_ptr = 0; m_rsp_v = 0; m_rsp_id = 0; m_mem_v = 0;
    m_mem_data = '0; m_mem_id = 0; m_err = 0;
  endfunction

  task automatic check_outputs();
    check("rsp_valid", rsp_valid_o, m_rsp_v);
    check("mem_valid", mem_valid_o, m_mem_v);
    if (m_rsp_v) check("rsp_data", rsp_data_o, m_rsp_id);
    if (m_mem_v) begin
      check("mem_data", mem_data_o, m_mem_data);
      check("mem_id", mem_id_o, m_mem_id);
    end
    check("outstanding", outstanding_o, m_count());
    check("free_err", free_err_o, m_err);
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit rr, input bit mr,
                       input bit fv, input int fid);
    req_valid_i  = v;
    req_data_i   = d;
    rsp_ready_i  = rr;
    mem_ready_i  = mr;
    free_valid_i = fv;
    free_id_i    = ID_WIDTH'(fid);
  endtask

  // One clock: check ready against the model, clock, then advance the model
  // and check the registered outputs. This task is entered between edges and
  // returns 1 time unit after the rising edge.
  task automatic cycle();
    int  pick;
    bit  exp_rdy, acc, fok;
    int  fid;
    pick    = m_pick();
    exp_rdy = rst_ni && pick >= 0 && (!m_rsp_v || rsp_ready_i) && (!m_mem_v || mem_ready_i);
    #1;
    check("req_ready", req_ready_o, exp_rdy);
    acc = req_valid_i && exp_rdy;
    fid = int'(free_id_i);
    fok = free_valid_i && fid < NUM_IDS && m_held[fid];
    @(posedge clk_i);
    if (acc) begin
      m_held[pick] = 1'b1;
      m_ptr      = (pick + 1) % NUM_IDS;
      m_rsp_v    = 1; m_rsp_id = pick;
      m_mem_v    = 1; m_mem_data = req_data_i; m_mem_id = pick;
    end else begin
      if (rsp_ready_i) m_rsp_v = 0;
      if (mem_ready_i) m_mem_v = 0;
    end
    if (fok) m_held[fid] = 1'b0;
    if (free_valid_i && !fok) m_err = 1;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values();
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_mem_id", mem_id_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_free_err", free_err_o, 0);
    check("rst_req_ready", req_ready_o, 0);
  endtask

  // Assert reset away from any edge, check it takes effect at once, and
  // release it on a falling edge.
  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    check_reset_values();
    m_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [31:0] held_data;

  initial begin
    drive(0, '0, 1, 1, 0, 0);
    rst_ni = 1'b0;
    m_reset();
    #1;
    do_reset();

    // Single request with both sinks ready.
    drive(1, 32'hCAFE_0000, 1, 1, 0, 0);
    cycle();
    check("single_rsp_data", rsp_data_o, 32'h0);
    check("single_mem_data", mem_data_o, 32'hCAFE_0000);
    check("single_mem_id", mem_id_o, 0);
    check("single_outstanding", outstanding_o, 1);

    // Four more back-to-back requests: IDs 1..3, then the pool is full.
    for (int i = 1; i < 5; i++) begin
      drive(1, 32'h1000_0000 + i, 1, 1, 0, 0);
      cycle();
      if (i < 4) check("b2b_id", mem_id_o, i);
    end
    check("full_ready", req_ready_o, 0);
    check("full_outstanding", outstanding_o, 4);

    // Release ID 2 while full: ready stays low this cycle, rises next.
    drive(1, 32'hBEEF_0002, 1, 1, 1, 2);
    cycle();
    drive(1, 32'hBEEF_0003, 1, 1, 0, 0);
    cycle();
    check("refill_id", mem_id_o, 2);

    // Drain the pool.
    for (int i = 0; i < NUM_IDS; i++) begin
      drive(0, '0, 1, 1, 1, i);
      cycle();
    end
    check("drained", outstanding_o, 0);

    // Reply backpressure: reply held, forward drains, ready low meanwhile.
    drive(1, 32'h5555_AAAA, 0, 1, 0, 0);
    cycle();
    held_data = rsp_data_o;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h7777_0000 + i, 0, 1, 0, 0);
      cycle();
      check("bp_rsp_stable", rsp_data_o, held_data);
    end
    check("bp_mem_dropped", mem_valid_o, 0);
    drive(0, '0, 1, 1, 0, 0);
    cycle();

    // Release of ID 1 while it is unallocated: error sticks.
    drive(0, '0, 1, 1, 1, 1);
    cycle();
    check("err_set", free_err_o, 1);
    check("err_outstanding", outstanding_o, 1);
    drive(0, '0, 1, 1, 0, 0);
    cycle();
    check("err_sticky", free_err_o, 1);

    // Reset with 3 IDs outstanding and both outputs valid.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3000_0000 + i, 1, 1, 0, 0);
      cycle();
    end
    check("pre_rst_outstanding", outstanding_o, 3);
    do_reset();
    drive(1, 32'h4444_4444, 1, 1, 0, 0);
    cycle();
    check("post_rst_id", mem_id_o, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int  fid;
      bit  fv;
      int  held_ids[$];
      held_ids.delete();
      for (int i = 0; i < NUM_IDS; i++) if (m_held[i]) held_ids.push_back(i);
      fv  = ($urandom_range(0, 99) < 35);
      fid = $urandom_range(0, NUM_IDS - 1);
      if (held_ids.size() > 0 && $urandom_range(0, 99) < 90)
        fid = held_ids[$urandom_range(0, held_ids.size() - 1)];
      drive($urandom_range(0, 99) < 65, $urandom,
            $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 75, fv, fid);
      cycle();
      if (n == 1500) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
